// File: rtl/instr_fetch_buffer_if.sv
// Fetch-buffer bus: instruction-memory request/response plus the
// instruction handshake and redirect toward the core.
// master = fetch buffer, slave = environment (memory model and core).
interface instr_fetch_buffer_if #(
    parameter int A_SIZE = 10,
    parameter int I_SIZE = 16
);
    logic              imem_req;
    logic [A_SIZE-1:0] imem_addr;
    logic [I_SIZE-1:0] imem_rdata;
    logic [I_SIZE-1:0] instr;
    logic [A_SIZE-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [A_SIZE-1:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues reads to a 1-cycle-latency instruction
// memory, keeps {instr, pc} in a DEPTH-entry prefetch FIFO and presents
// the head to the core with a valid/ready handshake. A redirect flushes the
// FIFO and restarts fetch at redirect_pc.
// Optional build macro IFB_STATS_EN adds the saturating stall_cnt and
// flush_cnt outputs.
module instr_fetch_buffer #(
    parameter int A_SIZE = 10,
    parameter int I_SIZE = 16,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    instr_fetch_buffer_if.master bus
`ifdef IFB_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [I_SIZE-1:0] instr;
        logic [A_SIZE-1:0] pc;
    } entry_t;

    entry_t            fifo_q [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [A_SIZE-1:0] fpc_q, fpc_d;
    logic [A_SIZE-1:0] pend_pc_q, pend_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic issue;
    logic push;
    logic pop;
    logic head_valid;

    // Credits come only from registered count/inflight, so a pop this
    // cycle frees its slot one cycle later and the FIFO cannot overflow.
    assign issue = !rst && !bus.redirect &&
                   ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    assign head_valid = (count_q != '0);
    assign pop  = head_valid && bus.instr_ready;
    assign push = inflight_q && !kill_q;

    assign bus.imem_req    = issue;
    assign bus.imem_addr   = fpc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? fifo_q[head_q].instr : '0;
    assign bus.instr_pc    = head_valid ? fifo_q[head_q].pc    : '0;

    // Next-state logic for pointers, occupancy, fetch PC and the in-flight tracker.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fpc_d      = fpc_q;
        pend_pc_d  = pend_pc_q;
        inflight_d = issue;
        kill_d     = 1'b0;

        if (bus.redirect) begin
            // Flush wins over push; a response still due next cycle is marked for drop.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            fpc_d   = bus.redirect_pc;
            kill_d  = issue;
        end else begin
            if (issue) begin
                fpc_d     = fpc_q + A_SIZE'(1);
                pend_pc_d = fpc_q;
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            fpc_q      <= '0;
            pend_pc_q  <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            fpc_q      <= fpc_d;
            pend_pc_q  <= pend_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    // FIFO storage write: capture the returning word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; empty entries are never visible because outputs are masked by count.
        if (!rst && !bus.redirect && push) begin
            fifo_q[tail_q] <= '{instr: bus.imem_rdata, pc: pend_pc_q};
        end
    end

`ifdef IFB_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters: head stalled by the core, and redirects seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (head_valid && !bus.instr_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (bus.redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: table of per-cycle vectors (inputs and
// hand-computed outputs) plus sequences for back-to-back redirects and,
// when IFB_STATS_EN is defined, the statistics counters.
// Memory model: synchronous, 1-cycle latency, mem[a] = a + 0x2800.
module tb_instr_fetch_buffer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    instr_fetch_buffer_if #(.A_SIZE(10), .I_SIZE(16)) bus ();

`ifdef IFB_STATS_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    instr_fetch_buffer #(.A_SIZE(10), .I_SIZE(16), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
`ifdef IFB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory model.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= 16'(bus.imem_addr) + 16'h2800;
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [9:0]  rpc;
        logic        req;
        logic [9:0]  addr;
        logic        valid;
        logic [15:0] instr;
        logic [9:0]  pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic rd, input logic [9:0] rpc,
                       input logic q, input logic [9:0] a, input logic v,
                       input logic [15:0] i, input logic [9:0] p);
        vec_t t;
        t = '{rst: r, ready: rdy, redir: rd, rpc: rpc, req: q, addr: a,
              valid: v, instr: i, pc: p};
        vecs.push_back(t);
    endtask

    // Drive one cycle's inputs after the falling edge and let outputs settle.
    task automatic cyc(input logic r, input logic rdy, input logic rd, input logic [9:0] rpc);
        @(negedge clk);
        rst             = r;
        bus.instr_ready = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        #1;
    endtask

    initial begin
        int lat;

        rst             = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);

        // rst rdy rd rpc | req addr valid instr pc
        add(1, 1, 0, 0,      0, 0,      0, 16'h0000, 0);       // in reset
        add(0, 1, 0, 0,      1, 0,      0, 16'h0000, 0);       // first req addr 0
        add(0, 1, 0, 0,      1, 1,      0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 2,      1, 16'h2800, 0);       // two cycles after release
        add(0, 1, 0, 0,      1, 3,      1, 16'h2801, 1);
        add(0, 1, 0, 0,      1, 4,      1, 16'h2802, 2);
        add(0, 0, 0, 0,      1, 5,      1, 16'h2803, 3);       // core stalls 10 cycles
        add(0, 0, 0, 0,      1, 6,      1, 16'h2803, 3);
        for (int k = 0; k < 8; k++)
            add(0, 0, 0, 0,  0, 7,      1, 16'h2803, 3);       // count+inflight = 4
        add(0, 1, 0, 0,      0, 7,      1, 16'h2803, 3);       // pop frees credit next cycle
        add(0, 1, 0, 0,      1, 7,      1, 16'h2804, 4);
        add(0, 1, 0, 0,      1, 8,      1, 16'h2805, 5);
        add(0, 1, 0, 0,      1, 9,      1, 16'h2806, 6);
        add(0, 1, 0, 0,      1, 10,     1, 16'h2807, 7);
        add(0, 0, 0, 0,      1, 11,     1, 16'h2808, 8);       // fill to 3 entries
        add(0, 0, 1, 10'h100, 0, 12,    1, 16'h2808, 8);       // redirect with req in flight
        add(0, 1, 0, 0,      1, 10'h100, 0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 10'h101, 0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 10'h102, 1, 16'h2900, 10'h100);
        add(0, 1, 0, 0,      1, 10'h103, 1, 16'h2901, 10'h101);
        add(0, 1, 1, 10'h3FE, 0, 10'h104, 1, 16'h2902, 10'h102); // redirect near top
        add(0, 1, 0, 0,      1, 10'h3FE, 0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 10'h3FF, 0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 10'h000, 1, 16'h2BFE, 10'h3FE);
        add(0, 1, 0, 0,      1, 10'h001, 1, 16'h2BFF, 10'h3FF);
        add(0, 1, 0, 0,      1, 10'h002, 1, 16'h2800, 10'h000); // wrapped
        add(0, 1, 0, 0,      1, 10'h003, 1, 16'h2801, 10'h001);
        add(1, 1, 0, 0,      0, 10'h004, 1, 16'h2802, 10'h002); // reset mid-stream
        add(0, 1, 0, 0,      1, 0,      0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 1,      0, 16'h0000, 0);
        add(0, 1, 0, 0,      1, 2,      1, 16'h2800, 0);
        add(0, 1, 0, 0,      1, 3,      1, 16'h2801, 1);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
            check("imem_req", i, 32'(bus.imem_req), 32'(vecs[i].req));
            if (vecs[i].req) check("imem_addr", i, 32'(bus.imem_addr), 32'(vecs[i].addr));
            check("instr_valid", i, 32'(bus.instr_valid), 32'(vecs[i].valid));
            check("instr", i, 32'(bus.instr), 32'(vecs[i].instr));
            check("instr_pc", i, 32'(bus.instr_pc), 32'(vecs[i].pc));
        end

        // Back-to-back redirects: the second one wins, no req during either.
        cyc(0, 1, 1, 10'h200);
        check("b2b_req0", 100, 32'(bus.imem_req), 32'd0);
        cyc(0, 1, 1, 10'h050);
        check("b2b_req1", 101, 32'(bus.imem_req), 32'd0);
        cyc(0, 1, 0, 0);
        check("b2b_addr", 102, 32'(bus.imem_addr), 32'h050);
        lat = 0;
        while (!bus.instr_valid && lat < 8) begin
            cyc(0, 1, 0, 0);
            lat++;
        end
        check("b2b_latency", 103, 32'(lat), 32'd2);
        check("b2b_pc0", 104, 32'(bus.instr_pc), 32'h050);
        check("b2b_instr0", 105, 32'(bus.instr), 32'h2850);
        cyc(0, 1, 0, 0);
        check("b2b_pc1", 106, 32'(bus.instr_pc), 32'h051);

`ifdef IFB_STATS_EN
        // 5 stall cycles and 2 redirects after a fresh reset.
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("stall_after_rst", 200, stall_cnt, 32'd0);
        check("flush_after_rst", 201, 32'(flush_cnt), 32'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("stats_valid", 202, 32'(bus.instr_valid), 32'd1);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 10'h020);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 10'h040);
        cyc(0, 1, 0, 0);
        check("stall_cnt", 203, stall_cnt, 32'd5);
        check("flush_cnt", 204, 32'(flush_cnt), 32'd2);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("stall_cleared", 205, stall_cnt, 32'd0);
        check("flush_cleared", 206, 32'(flush_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
